// File: rtl/pad_cfg_pkg.sv
// pad_cfg_pkg: shared sizes, reset defaults, FSM state and request record for pad_cfg_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pad_cfg_pkg;

    localparam int N_IO        = 48;
    localparam int NBIT_PADCFG = 6;
    localparam int MUX_W       = 2;
    localparam int NREQ        = 2;
    localparam int PAD_IDX_W   = 6;

    localparam logic [NBIT_PADCFG-1:0] DEFAULT_CFG = 6'h01;
    // tck, ref_clk and rstn pads must never be reconfigured at runtime
    localparam logic [N_IO-1:0]        RSVD_MASK   = 48'h0000_0000_0061;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic [PAD_IDX_W-1:0]   pad;
        logic [NBIT_PADCFG-1:0] cfg;
        logic [MUX_W-1:0]       mux;
    } pad_req_t;

    // A pad is writable only if it exists and is not reserved
    function automatic logic pad_writable(input logic [PAD_IDX_W-1:0] pad);
        logic [63:0] mask_ext;
        mask_ext = 64'(RSVD_MASK);
        return (pad < PAD_IDX_W'(N_IO)) && !mask_ext[pad];
    endfunction

endpackage

// File: rtl/pad_cfg_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters, pointer advances past each winner.
// Latency: grant is combinational in the request cycle; pointer updates at the clock edge.
// Backpressure: no grant while en_i is low; unserved requesters simply wait.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    logic [IW-1:0] ptr_q;

    // Scan from the pointer, wrapping; first valid requester wins
    always_comb begin
        logic          found;
        logic [IW-1:0] j;
        found     = 1'b0;
        j         = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_q) + k) % N);
            if (en_i && !found && req_i[j]) begin
                found     = 1'b1;
                gnt_idx_o = j;
                gnt_o[j]  = 1'b1;
            end
        end
        gnt_vld_o = found;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (gnt_vld_o) begin
            ptr_q <= (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + IW'(1);
        end
    end

endmodule

// File: rtl/pad_cfg_ctrl.sv
// pad_cfg_ctrl: per-pad config/mux registers, default walk after reset, RR-arbitrated runtime writes.
// Latency: INIT walk takes N_IO cycles; an accepted write lands and pulses resp one cycle later.
// Backpressure: req_ready_o is the one-hot grant, held 0 during INIT. Optional PAD_CFG_LOCK_EN adds lock_i.
module pad_cfg_ctrl
    import pad_cfg_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef PAD_CFG_LOCK_EN
    input  logic                          lock_i,
`endif
    input  logic [NREQ-1:0]               req_valid_i,
    output logic [NREQ-1:0]               req_ready_o,
    input  logic [NREQ*PAD_IDX_W-1:0]     req_pad_i,
    input  logic [NREQ*NBIT_PADCFG-1:0]   req_cfg_i,
    input  logic [NREQ*MUX_W-1:0]         req_mux_i,
    output logic [NREQ-1:0]               resp_valid_o,
    output logic                          resp_err_o,
    output logic [N_IO*NBIT_PADCFG-1:0]   pad_cfg_o,
    output logic [N_IO*MUX_W-1:0]         pad_mux_o,
    output logic                          init_done_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t                 state_q;
    logic [PAD_IDX_W-1:0]   cnt_q;
    logic [NBIT_PADCFG-1:0] cfg_q [N_IO];
    logic [MUX_W-1:0]       mux_q [N_IO];
    logic [NREQ-1:0]        resp_valid_q;
    logic                   resp_err_q;
    logic                   init_done_q;

    pad_req_t               req [NREQ];
    pad_req_t               sel;
    logic [NREQ-1:0]        gnt;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_vld;
    logic                   wr_ok;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_req
            assign req[g].pad = req_pad_i[g*PAD_IDX_W +: PAD_IDX_W];
            assign req[g].cfg = req_cfg_i[g*NBIT_PADCFG +: NBIT_PADCFG];
            assign req[g].mux = req_mux_i[g*MUX_W +: MUX_W];
        end
        for (g = 0; g < N_IO; g++) begin : g_pad
            assign pad_cfg_o[g*NBIT_PADCFG +: NBIT_PADCFG] = cfg_q[g];
            assign pad_mux_o[g*MUX_W +: MUX_W]             = mux_q[g];
        end
    endgenerate

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (state_q == RUN),
        .req_i     (req_valid_i),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign sel = req[gnt_idx];

`ifdef PAD_CFG_LOCK_EN
    logic lock_prev_q;
    logic locked_q;

    // Sticky lock armed by a rising lock_i once running; only reset clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_prev_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            lock_prev_q <= lock_i;
            if (state_q == RUN && lock_i && !lock_prev_q) begin
                locked_q <= 1'b1;
            end
        end
    end

    assign wr_ok = pad_writable(sel.pad) && !locked_q;
`else
    assign wr_ok = pad_writable(sel.pad);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < N_IO; i++) begin
                cfg_q[i] <= DEFAULT_CFG;
                mux_q[i] <= '0;
            end
        end else begin
            case (state_q)
                INIT: begin
                    resp_valid_q  <= '0;
                    resp_err_q    <= 1'b0;
                    cfg_q[cnt_q]  <= DEFAULT_CFG;
                    mux_q[cnt_q]  <= '0;
                    if (cnt_q == PAD_IDX_W'(N_IO - 1)) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + PAD_IDX_W'(1);
                    end
                end
                RUN: begin
                    resp_valid_q <= gnt;
                    resp_err_q   <= gnt_vld && !wr_ok;
                    if (gnt_vld && wr_ok) begin
                        cfg_q[sel.pad] <= sel.cfg;
                        mux_q[sel.pad] <= sel.mux;
                    end
                end
                default: begin
                    state_q <= INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign req_ready_o  = gnt;
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign init_done_o  = init_done_q;

endmodule

// File: doc/pad_cfg_ctrl.md
Name: pad_cfg_ctrl

Overview:
Owns the per-pad configuration and function-select state for all N_IO FPGA/ASIC pads of core_v_mcu. After reset it walks every pad and loads defaults, one pad per cycle. It then accepts runtime write requests from NREQ requesters, such as the APB pad-control bridge and the JTAG debug path. Requesters are served by round-robin arbitration over a valid/ready handshake. Outputs drive the pad_cfg and pad-mux inputs of the pad ring.

Parameters:
N_IO, 48, number of pads
NBIT_PADCFG, 6, config bits per pad (bit0 = pull enable)
MUX_W, 2, function-select bits per pad
NREQ, 2, number of write requesters
DEFAULT_CFG, 6'h01, reset config for every pad
RSVD_MASK, 48'h0000_0000_0061, pads that cannot be written (tck, ref_clk, rstn)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NREQ  write request valid, one bit per requester
req_ready_o  out  NREQ  request accepted in this cycle
req_pad_i  in  NREQ*6  target pad index, flattened per requester
req_cfg_i  in  NREQ*NBIT_PADCFG  new config
req_mux_i  in  NREQ*MUX_W  new function select
resp_valid_o  out  NREQ  one-cycle completion pulse
resp_err_o  out  1  error flag qualified by resp_valid_o
pad_cfg_o  out  N_IO*NBIT_PADCFG  per-pad config
pad_mux_o  out  N_IO*MUX_W  per-pad function select
init_done_o  out  1  default walk complete

Behaviour:
- Reset: clk_i and rst_i only. Reset is synchronous and active-high.
- Reset values: all pad_cfg_o = DEFAULT_CFG; all pad_mux_o = 0; req_ready_o = 0; resp_valid_o = 0; resp_err_o = 0; init_done_o = 0; state = INIT; walk counter = 0; RR pointer = 0.
- FSM states:
  - INIT: write DEFAULT_CFG and mux 0 to pad[cnt], one pad per cycle. cnt = N_IO-1 -> RUN, with init_done_o = 1 from the next cycle. Total N_IO cycles after reset deasserts. req_ready_o stays 0 throughout.
  - RUN: arbitrate requesters.
- Arbitration (RUN):
  - Grant the first valid requester at or after the RR pointer, wrapping. Combinational within the cycle.
  - req_ready_o is one-hot to the granted requester; it is 0 when no request is valid.
  - On grant, the pointer moves to grant+1 mod NREQ. With a single requester active, it is served every cycle.
- Write (accept in cycle T):
  - Pad registers update at the end of T, so outputs change in T+1.
  - resp_valid_o[grant] pulses high in T+1.
  - Back-to-back accepts are allowed with no bubble.
- Error cases:
  - req_pad_i >= N_IO or RSVD_MASK[pad] = 1: no register update, resp_err_o = 1 in T+1.
  - Otherwise resp_err_o = 0.
- rst_i mid-operation: a pending response is dropped and INIT restarts from pad 0.
- Unused pads (index >= N_IO) do not exist; no wrap-around write is possible.

Optional Feature:
PAD_CFG_LOCK_EN
- When defined: adds input lock_i (1 bit).
  - A rising lock_i in RUN sets a sticky lock bit, cleared only by rst_i.
  - While locked, every accepted request gets resp_err_o = 1 and makes no update. Handshake timing is unchanged.
- When undefined: no lock_i port; behaviour as above.

Decomposition:
- Package pad_cfg_pkg holds:
  - state enum (INIT, RUN)
  - PAD_IDX_W = 6
  - default constants DEFAULT_CFG and RSVD_MASK
  - typedef pad_req_t {pad, cfg, mux}
- One sub-module, rr_arbiter (NREQ-wide, pointer register plus one-hot grant), instantiated once.

Test Plan:
- Release rst_i -> req_ready_o = 0 for 48 cycles; init_done_o = 1 at cycle 48; all pad_cfg_o fields = 6'h01 and pad_mux_o = 0.
- Requester0 writes pad 10, cfg 6'h3E, mux 2 -> ready in T; pad_cfg_o[10] = 6'h3E and pad_mux_o[10] = 2 in T+1; resp_valid_o = 2'b01, resp_err_o = 0.
- Both requesters valid continuously for 4 cycles -> grants alternate 0,1,0,1; both pads updated; pointer wraps correctly.
- Write to pad 5 (reserved), then to pad 50 -> resp_err_o = 1 for both; pad_cfg_o unchanged.
- Assert rst_i for 1 cycle during RUN with a write accepted that same cycle -> no resp_valid_o; INIT restarts; pad reverts to default.
- With PAD_CFG_LOCK_EN: pulse lock_i, then write pad 20 -> resp_err_o = 1, no update; after rst_i, a write to pad 20 succeeds.
